// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: shared state encoding and defaults for the SR command debouncer.
// Rev 1.0
`default_nettype none

package sr_cmd_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 4;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    CH_IDLE         = ST_IDLE,
    CH_PRESS_WAIT   = ST_PRESS_WAIT,
    CH_PRESSED      = ST_PRESSED,
    CH_RELEASE_WAIT = ST_RELEASE_WAIT
  } chan_state_e;

  // The debounced level stays high until a release has been fully qualified.
  function automatic logic state_is_held(input chan_state_e st);
    return (st == CH_PRESSED) || (st == CH_RELEASE_WAIT);
  endfunction

endpackage : sr_cmd_pkg

`default_nettype wire

// File: rtl/debounce_chan.sv
// debounce_chan: 2-flop synchroniser, press/release qualification FSM,
// registered single-shot press event and debounced held level. Rev 1.0
`default_nettype none

module debounce_chan
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             sync_w;
  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign sync_w = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // cnt counts consecutive samples that disagree with the current level;
  // it is reloaded before it can pass CNT_LAST, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      CH_IDLE: begin
        cnt_d = '0;
        if (sync_w) begin
          state_d = CH_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      CH_PRESS_WAIT: begin
        if (!sync_w) begin
          state_d = CH_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = CH_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CH_PRESSED: begin
        cnt_d = '0;
        if (!sync_w) begin
          state_d = CH_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      CH_RELEASE_WAIT: begin
        if (sync_w) begin
          state_d = CH_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = CH_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = CH_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign press_o = press_q;
  assign held_o  = state_is_held(state_q);

endmodule : debounce_chan

`default_nettype wire

// File: rtl/sr_cmd_debounce.sv
// sr_cmd_debounce: two debounced button channels plus a registered arbiter
// producing mutually exclusive one-cycle set/reset commands. Rev 1.0
`default_nettype none

module sr_cmd_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_reset,
  output logic s,
  output logic r,
  output logic conflict,
  output logic set_held,
  output logic reset_held
);

  logic set_ev_w, reset_ev_w;
  logic set_lvl_w, reset_lvl_w;

  logic s_q, s_d;
  logic r_q, r_d;
  logic conflict_q, conflict_d;
  logic set_held_q, reset_held_q;

  debounce_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_set_chan (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_set),
    .press_o (set_ev_w),
    .held_o  (set_lvl_w)
  );

  debounce_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_reset_chan (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_reset),
    .press_o (reset_ev_w),
    .held_o  (reset_lvl_w)
  );

  // Simultaneous events cancel each other so the latch never sees s=r=1.
  always_comb begin
    s_d        = 1'b0;
    r_d        = 1'b0;
    conflict_d = 1'b0;
    if (set_ev_w && reset_ev_w) begin
      conflict_d = 1'b1;
    end else if (set_ev_w) begin
      s_d = 1'b1;
    end else if (reset_ev_w) begin
      r_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      conflict_q   <= 1'b0;
      set_held_q   <= 1'b0;
      reset_held_q <= 1'b0;
    end else begin
      s_q          <= s_d;
      r_q          <= r_d;
      conflict_q   <= conflict_d;
      set_held_q   <= set_lvl_w;
      reset_held_q <= reset_lvl_w;
    end
  end

  assign s          = s_q;
  assign r          = r_q;
  assign conflict   = conflict_q;
  assign set_held   = set_held_q;
  assign reset_held = reset_held_q;

endmodule : sr_cmd_debounce

`default_nettype wire
